// File: rtl/stream_mux_rr_if.sv
`default_nettype none
// ============================================================================
//  Module   : stream_mux_rr_if
//  Purpose  : Bundle of the N input streams, the fixed-select controls and the
//             single output stream of stream_mux_rr.
//             master = producer/consumer side, slave = multiplexer side.
//  Revision : 1.0  initial release
// ============================================================================
interface stream_mux_rr_if #(
   parameter int SIZE = 8,
   parameter int N    = 4
);
   localparam int SELW = $clog2(N);

   logic [N*SIZE-1:0] in_data;
   logic [N-1:0]      in_valid;
   logic [N-1:0]      in_ready;
   logic              fixed_en;
   logic [SELW-1:0]   fixed_sel;
   logic [SIZE-1:0]   out_data;
   logic [SELW-1:0]   out_chan;
   logic              out_valid;
   logic              out_ready;

   modport master (
      output in_data, in_valid, fixed_en, fixed_sel, out_ready,
      input  in_ready, out_data, out_chan, out_valid
   );

   modport slave (
      input  in_data, in_valid, fixed_en, fixed_sel, out_ready,
      output in_ready, out_data, out_chan, out_valid
   );
endinterface
`default_nettype wire

// File: rtl/stream_mux_rr.sv
`default_nettype none
// ============================================================================
//  Module   : stream_mux_rr
//  Purpose  : N-channel registered stream multiplexer. One input is granted per
//             cycle, either round-robin (starting at the channel after the
//             last winner) or by a fixed channel index. The granted word and
//             its channel index are captured in a single output register.
//  Revision : 1.0  initial release
// ============================================================================
module stream_mux_rr #(
   parameter int SIZE = 8,
   parameter int N    = 4
) (
   input  logic               clk,
   input  logic               rst_n,
   stream_mux_rr_if.slave     sif
);

   localparam int SELW = $clog2(N);

   // Constants sized to the index width; the scan sum carries one extra bit
   // so that ptr + offset never overflows before the wrap correction.
   localparam int              C_LAST_I = N - 1;
   localparam int              C_ONE_I  = 1;
   localparam logic [SELW:0]   C_N      = N[SELW:0];
   localparam logic [SELW-1:0] C_LAST   = C_LAST_I[SELW-1:0];
   localparam logic [SELW-1:0] C_ONE    = C_ONE_I[SELW-1:0];

   // ---------------------------------------------------------------------
   // State
   // ---------------------------------------------------------------------
   logic [SIZE-1:0] out_data_q,  out_data_d;
   logic [SELW-1:0] out_chan_q,  out_chan_d;
   logic            out_valid_q, out_valid_d;
   logic [SELW-1:0] ptr_q,       ptr_d;

   // ---------------------------------------------------------------------
   // Combinational
   // ---------------------------------------------------------------------
   logic            load_en;
   logic [SELW:0]   rr_sum;
   logic [SELW-1:0] rr_lo;
   logic            rr_vld;
   logic [SELW-1:0] rr_idx;
   logic            fx_vld;
   logic            grant_vld;
   logic [SELW-1:0] grant_idx;
   logic [SIZE-1:0] grant_data;
   logic [N-1:0]    ready_w;

   // The output register may take a new word when empty or being drained.
   assign load_en = !out_valid_q || sif.out_ready;

   // Round-robin scan: first valid channel at ptr, ptr+1, ..., wrapping at N.
   always_comb begin
      rr_vld = 1'b0;
      rr_idx = '0;
      rr_sum = '0;
      rr_lo  = '0;
      for (int k = 0; k < N; k++) begin
         rr_sum = {1'b0, ptr_q} + k[SELW:0];
         if (rr_sum >= C_N) begin
            rr_sum = rr_sum - C_N;
         end
         rr_lo = rr_sum[SELW-1:0];
         if (!rr_vld && sif.in_valid[rr_lo]) begin
            rr_vld = 1'b1;
            rr_idx = rr_lo;
         end
      end
   end

   // Fixed mode: an out-of-range fixed_sel matches no channel and is never granted.
   always_comb begin
      fx_vld = 1'b0;
      for (int i = 0; i < N; i++) begin
         if (sif.fixed_sel == i[SELW-1:0] && sif.in_valid[i]) begin
            fx_vld = 1'b1;
         end
      end
   end

   assign grant_vld = load_en && (sif.fixed_en ? fx_vld : rr_vld);
   assign grant_idx = sif.fixed_en ? sif.fixed_sel : rr_idx;

   // Per-channel ready: only the granted channel, and never while in reset.
   generate
      for (genvar gi = 0; gi < N; gi++) begin : g_ready
         assign ready_w[gi] = rst_n && grant_vld && (grant_idx == gi[SELW-1:0]);
      end
   endgenerate

   assign sif.in_ready = ready_w;

   // Data select for the granted channel (loop form avoids a width-mismatched multiply).
   always_comb begin
      grant_data = '0;
      for (int i = 0; i < N; i++) begin
         if (grant_idx == i[SELW-1:0]) begin
            grant_data = sif.in_data[i*SIZE +: SIZE];
         end
      end
   end

   // Next state: load on a grant, empty the register on a drain with no grant, else hold.
   always_comb begin
      out_data_d  = out_data_q;
      out_chan_d  = out_chan_q;
      out_valid_d = out_valid_q;
      ptr_d       = ptr_q;
      if (load_en) begin
         if (grant_vld) begin
            out_data_d  = grant_data;
            out_chan_d  = grant_idx;
            out_valid_d = 1'b1;
            ptr_d       = (grant_idx == C_LAST) ? '0 : grant_idx + C_ONE;
         end else begin
            out_valid_d = 1'b0;
         end
      end
   end

   // Output register and round-robin pointer; reset drops any pending word.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         out_data_q  <= '0;
         out_chan_q  <= '0;
         out_valid_q <= 1'b0;
         ptr_q       <= '0;
      end else begin
         out_data_q  <= out_data_d;
         out_chan_q  <= out_chan_d;
         out_valid_q <= out_valid_d;
         ptr_q       <= ptr_d;
      end
   end

   assign sif.out_data  = out_data_q;
   assign sif.out_chan  = out_chan_q;
   assign sif.out_valid = out_valid_q;

endmodule
`default_nettype wire

// File: tb/tb_stream_mux_rr.sv
`default_nettype none
// ============================================================================
//  Module   : tb_stream_mux_rr
//  Purpose  : Directed and short randomised checks of stream_mux_rr with N=4,
//             plus an N=3 instance for the out-of-range fixed select.
//  Revision : 1.0  initial release
// ============================================================================
module tb_stream_mux_rr;

   logic clk;
   logic rst_n;
   int   total;
   int   bad;

   stream_mux_rr_if #(.SIZE(8), .N(4)) if4 ();
   stream_mux_rr_if #(.SIZE(8), .N(3)) if3 ();

   stream_mux_rr #(.SIZE(8), .N(4)) dut4 (
      .clk   (clk),
      .rst_n (rst_n),
      .sif   (if4.slave)
   );

   stream_mux_rr #(.SIZE(8), .N(3)) dut3 (
      .clk   (clk),
      .rst_n (rst_n),
      .sif   (if3.slave)
   );

   // 10-time-unit clock
   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   logic [15:0] q[$];
   logic [15:0] front;
   logic        hold_prev;
   logic [7:0]  prev_data;
   logic [1:0]  prev_chan;
   int          sp[4];

   initial begin
      total = 0;
      bad   = 0;
      sp    = '{1, 3, 1, 3};

      rst_n         = 1'b0;
      if4.in_data   = {8'hA3, 8'hA2, 8'hA1, 8'hA0};
      if4.in_valid  = 4'b1111;
      if4.fixed_en  = 1'b0;
      if4.fixed_sel = 2'd0;
      if4.out_ready = 1'b0;
      if3.in_data   = {8'hC2, 8'hC1, 8'hC0};
      if3.in_valid  = 3'b000;
      if3.fixed_en  = 1'b0;
      if3.fixed_sel = 2'd0;
      if3.out_ready = 1'b1;

      // Reset state
      #1;
      chk("rst_in_ready", 32'(if4.in_ready), 32'h0);
      chk("rst_out_valid", 32'(if4.out_valid), 32'h0);
      chk("rst_out_data", 32'(if4.out_data), 32'h0);
      chk("rst_out_chan", 32'(if4.out_chan), 32'h0);
      tick();
      tick();
      chk("rst_in_ready_held", 32'(if4.in_ready), 32'h0);
      chk("rst_out_valid_held", 32'(if4.out_valid), 32'h0);

      // Release: full rotation 0,1,2,3,0
      rst_n         = 1'b1;
      if4.out_ready = 1'b1;
      #1;
      chk("first_ready", 32'(if4.in_ready), 32'h1);
      for (int c = 0; c < 5; c++) begin
         tick();
         chk("rot_valid", 32'(if4.out_valid), 32'h1);
         chk("rot_chan", 32'(if4.out_chan), 32'(c % 4));
         chk("rot_data", 32'(if4.out_data), 32'hA0 + 32'(c % 4));
      end

      // Sparse: channels 1 and 3 only
      if4.in_valid = 4'b1010;
      for (int c = 0; c < 4; c++) begin
         tick();
         chk("sparse_chan", 32'(if4.out_chan), 32'(sp[c]));
         chk("sparse_data", 32'(if4.out_data), 32'hA0 + 32'(sp[c]));
      end
      // Channel 3 alone after a grant of 3: pointer wrapped to 0, 3 wins again
      if4.in_valid = 4'b1000;
      #1;
      chk("alone3_ready", 32'(if4.in_ready), 32'h8);
      tick();
      chk("alone3_chan", 32'(if4.out_chan), 32'h3);
      tick();
      chk("alone3_chan2", 32'(if4.out_chan), 32'h3);
      chk("alone3_data2", 32'(if4.out_data), 32'hA3);

      // Backpressure with word 5C from channel 2
      if4.in_data[23:16] = 8'h5C;
      if4.in_valid       = 4'b0100;
      #1;
      chk("bp_ready_pre", 32'(if4.in_ready), 32'h4);
      tick();
      chk("bp_load_data", 32'(if4.out_data), 32'h5C);
      chk("bp_load_chan", 32'(if4.out_chan), 32'h2);
      if4.out_ready = 1'b0;
      if4.in_valid  = 4'b1111;
      for (int c = 0; c < 5; c++) begin
         #1;
         chk("bp_in_ready", 32'(if4.in_ready), 32'h0);
         tick();
         chk("bp_valid", 32'(if4.out_valid), 32'h1);
         chk("bp_data", 32'(if4.out_data), 32'h5C);
         chk("bp_chan", 32'(if4.out_chan), 32'h2);
      end
      if4.out_ready = 1'b1;
      #1;
      chk("bp_release_ready", 32'(if4.in_ready), 32'h8);
      tick();
      chk("bp_refill_valid", 32'(if4.out_valid), 32'h1);
      chk("bp_refill_chan", 32'(if4.out_chan), 32'h3);
      chk("bp_refill_data", 32'(if4.out_data), 32'hA3);
      if4.in_data[23:16] = 8'hA2;

      // Fixed mode on channel 2
      if4.fixed_en  = 1'b1;
      if4.fixed_sel = 2'd2;
      for (int c = 0; c < 3; c++) begin
         #1;
         chk("fx_ready", 32'(if4.in_ready), 32'h4);
         tick();
         chk("fx_chan", 32'(if4.out_chan), 32'h2);
         chk("fx_data", 32'(if4.out_data), 32'hA2);
      end
      if4.in_valid = 4'b1011;
      #1;
      chk("fx_nogrant_ready", 32'(if4.in_ready), 32'h0);
      tick();
      chk("fx_drain_valid", 32'(if4.out_valid), 32'h0);
      chk("fx_drain_chan_hold", 32'(if4.out_chan), 32'h2);
      chk("fx_drain_data_hold", 32'(if4.out_data), 32'hA2);
      // Back to round-robin: pointer is 3 after the fixed grants of 2
      if4.fixed_en = 1'b0;
      #1;
      chk("rr_resume_ready", 32'(if4.in_ready), 32'h8);
      tick();
      chk("rr_resume_chan", 32'(if4.out_chan), 32'h3);
      if4.in_valid = 4'b0010;
      tick();
      chk("pre_reset_chan", 32'(if4.out_chan), 32'h1);
      chk("pre_reset_valid", 32'(if4.out_valid), 32'h1);

      // Asynchronous reset mid-operation (pointer is 2 here)
      rst_n = 1'b0;
      #1;
      chk("mid_rst_valid", 32'(if4.out_valid), 32'h0);
      chk("mid_rst_data", 32'(if4.out_data), 32'h0);
      chk("mid_rst_chan", 32'(if4.out_chan), 32'h0);
      chk("mid_rst_ready", 32'(if4.in_ready), 32'h0);
      tick();
      if4.in_valid = 4'b1111;
      rst_n        = 1'b1;
      #1;
      chk("post_rst_ready", 32'(if4.in_ready), 32'h1);
      tick();
      chk("post_rst_chan", 32'(if4.out_chan), 32'h0);
      chk("post_rst_data", 32'(if4.out_data), 32'hA0);

      // N=3: fixed_sel=3 is out of range and never granted
      if3.fixed_en  = 1'b1;
      if3.fixed_sel = 2'd3;
      if3.in_valid  = 3'b111;
      for (int c = 0; c < 3; c++) begin
         #1;
         chk("n3_oor_ready", 32'(if3.in_ready), 32'h0);
         tick();
         chk("n3_oor_valid", 32'(if3.out_valid), 32'h0);
      end
      if3.fixed_sel = 2'd2;
      #1;
      chk("n3_fx2_ready", 32'(if3.in_ready), 32'h4);
      tick();
      chk("n3_fx2_chan", 32'(if3.out_chan), 32'h2);
      chk("n3_fx2_data", 32'(if3.out_data), 32'hC2);
      if3.fixed_en = 1'b0;
      #1;
      chk("n3_wrap_ready", 32'(if3.in_ready), 32'h1);
      tick();
      chk("n3_wrap_chan", 32'(if3.out_chan), 32'h0);
      chk("n3_wrap_data", 32'(if3.out_data), 32'hC0);

      // Randomised traffic with an in-order scoreboard
      if4.in_valid  = 4'b0000;
      if4.out_ready = 1'b1;
      if4.fixed_en  = 1'b0;
      tick();
      chk("rnd_start_empty", 32'(if4.out_valid), 32'h0);
      q.delete();
      hold_prev = 1'b0;
      prev_data = '0;
      prev_chan = '0;
      for (int cyc = 0; cyc < 300; cyc++) begin
         if (hold_prev) begin
            chk("rnd_hold_valid", 32'(if4.out_valid), 32'h1);
            chk("rnd_hold_data", 32'(if4.out_data), 32'(prev_data));
            chk("rnd_hold_chan", 32'(if4.out_chan), 32'(prev_chan));
         end
         if4.in_data   = $urandom;
         if4.in_valid  = 4'($urandom);
         if4.out_ready = ($urandom_range(0, 3) != 0);
         if4.fixed_en  = ($urandom_range(0, 3) == 0);
         if4.fixed_sel = 2'($urandom);
         #1;
         chk("rnd_onehot", 32'($onehot0(if4.in_ready)), 32'h1);
         chk("rnd_subset", 32'(if4.in_ready & ~if4.in_valid), 32'h0);
         if (if4.out_valid && !if4.out_ready) begin
            chk("rnd_stall_ready", 32'(if4.in_ready), 32'h0);
         end
         if (if4.out_valid && if4.out_ready) begin
            if (q.size() == 0) begin
               chk("rnd_underflow", 32'h1, 32'(q.size()));
            end else begin
               front = q.pop_front();
               chk("rnd_out_chan", 32'(if4.out_chan), 32'(front[15:8]));
               chk("rnd_out_data", 32'(if4.out_data), 32'(front[7:0]));
            end
         end
         for (int i = 0; i < 4; i++) begin
            if (if4.in_valid[i] && if4.in_ready[i]) begin
               q.push_back({8'(i), if4.in_data[i*8 +: 8]});
            end
         end
         hold_prev = if4.out_valid && !if4.out_ready;
         prev_data = if4.out_data;
         prev_chan = if4.out_chan;
         tick();
      end
      // Drain what is left in the output register
      if4.in_valid  = 4'b0000;
      if4.out_ready = 1'b1;
      for (int c = 0; c < 3; c++) begin
         #1;
         if (if4.out_valid) begin
            if (q.size() == 0) begin
               chk("drain_underflow", 32'h1, 32'(q.size()));
            end else begin
               front = q.pop_front();
               chk("drain_chan", 32'(if4.out_chan), 32'(front[15:8]));
               chk("drain_data", 32'(if4.out_data), 32'(front[7:0]));
            end
         end
         tick();
      end
      chk("drain_queue_empty", 32'(q.size()), 32'h0);
      chk("drain_out_valid", 32'(if4.out_valid), 32'h0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/stream_mux_rr.md
Name: stream_mux_rr

Overview:
- N-channel registered stream multiplexer with valid/ready handshakes on every input and on the single output.
- Selects one input per cycle using round-robin arbitration, or using a fixed software-style select when fixed mode is on.
- Registers the selected word together with its channel index.
- Sits between multiple producers (e.g. register-file/ALU result sources) and one consumer in the datapath. It is the sequential, flow-controlled generalisation of the plain N:1 select mux.

Parameters:
- SIZE, 8, data width per channel in bits.
- N, 4, number of input channels; N >= 2, need not be a power of two.
- SELW, $clog2(N), derived localparam giving the width of channel indices; not overridable.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous reset, active-low.
- in_data  input  N*SIZE  packed channel data; channel i occupies bits [i*SIZE +: SIZE].
- in_valid  input  N  per-channel valid.
- in_ready  output  N  per-channel ready (combinational).
- fixed_en  input  1  1 = fixed-select mode, 0 = round-robin mode.
- fixed_sel  input  SELW  channel index used when fixed_en = 1.
- out_data  output  SIZE  registered selected data.
- out_chan  output  SELW  registered index of the channel that out_data came from.
- out_valid  output  1  registered output valid.
- out_ready  input  1  downstream ready.

Behaviour:
- Interface: one clock; reset is asynchronous and active-low (clk, rst_n).
- Reset, applied asynchronously: out_valid = 0, out_data = 0, out_chan = 0, round-robin pointer ptr = 0.
- in_ready is 0 for all channels while rst_n = 0.
- load_en = !out_valid || out_ready. This is the output register's free-or-draining condition.
- Grant selection (combinational, evaluated only when load_en = 1):
  - Round-robin mode: grant the first i with in_valid[i] = 1, scanning ptr, ptr+1, …, N-1, 0, …, ptr-1.
  - Fixed mode: grant fixed_sel only if fixed_sel < N and in_valid[fixed_sel] = 1; otherwise no grant.
- in_ready[i] = load_en && grant exists && grant == i. At most one bit of in_ready is set.
- in_ready must not depend on in_valid of the same channel beyond the grant scan; this keeps the path free of combinational loops.
- Transfer on channel g (in_valid[g] && in_ready[g]), at the next rising edge:
  - out_data <= in_data[g], out_chan <= g, out_valid <= 1.
  - ptr <= (g == N-1) ? 0 : g+1. The pointer updates in both modes.
- load_en = 1 with no grant: out_valid <= 0. out_data, out_chan and ptr hold.
- load_en = 0 (out_valid = 1, out_ready = 0): out_data, out_chan, out_valid and ptr hold; all in_ready = 0.
- Latency: 1 cycle from input handshake to out_valid.
- Throughput: 1 word per cycle when out_ready is held at 1 (simultaneous drain and refill).
- Fairness: in round-robin mode with all N channels continuously valid, grants rotate 0,1,…,N-1,0; no channel waits more than N-1 transfers.
- Changing fixed_en or fixed_sel affects only the current grant decision. A word already in the output register is never modified.
- Reset asserted mid-transfer: the output register clears immediately and the pending word is dropped; the first grant after release starts the scan at channel 0.

Test Plan:
- Reset: drive all in_valid = 4'b1111 with rst_n = 0 -> in_ready = 0, out_valid = 0. Release rst_n, out_ready = 1 -> first out_chan = 0, then 1, 2, 3, 0 on consecutive cycles, with out_data matching each channel's value (e.g. 8'hA0, 8'hA1, 8'hA2, 8'hA3).
- Sparse round-robin: only channels 1 and 3 valid, ptr = 0 -> grants 1, 3, 1, 3. Then channel 3 alone valid after a grant of 3 -> pointer wraps to 0 and 3 is granted again.
- Backpressure: hold out_ready = 0 after a word 8'h5C from channel 2 -> out_valid = 1 and out_data = 8'h5C stable, in_ready = 0 for 5 cycles. Raise out_ready -> the next word loads in the same cycle as the drain.
- Fixed mode: fixed_en = 1, fixed_sel = 2, all valid -> only channel 2 is granted every cycle. With fixed_sel = 2 and in_valid[2] = 0 -> no grant, and out_valid drops to 0 after the drain. For N = 3, fixed_sel = 3 -> never granted.
- Mid-operation reset: pull rst_n low asynchronously while out_valid = 1 -> out_valid and out_data go to 0 before the next clock edge; after release, the first grant is channel 0.
- Random: random in_valid, out_ready and mode per cycle -> a scoreboard confirms every accepted input appears exactly once, in order, with the correct out_chan, and that no data changes while out_valid && !out_ready.
